// File: rtl/stopwatch_lap_timer.sv
// stopwatch_lap_timer: run/hold stopwatch with up/down counting, a wrap
// pulse and a lap-capture FIFO drained by the host over valid/ready.
//
// Optional build macro STOPWATCH_PRESET_EN adds preset_load/preset_value,
// which load the count while the FSM is in IDLE or HOLD.
//
// Lap handshake: an entry transfers on every rising edge where lap_valid
// and lap_ready are both high. lap_data is stable while lap_valid is high
// and lap_ready is low. lap_ready is ignored while lap_valid is low.
module stopwatch_lap_timer #(
  parameter int DATA_WIDTH = 16,
  parameter int MAX        = 99,
  parameter int LAP_DEPTH  = 4
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  clear,
  input  logic                  dir,
  input  logic                  lap,
  input  logic                  lap_ready,
`ifdef STOPWATCH_PRESET_EN
  input  logic                  preset_load,
  input  logic [DATA_WIDTH-1:0] preset_value,
`endif
  output logic [DATA_WIDTH-1:0] count,
  output logic                  running,
  output logic                  wrap,
  output logic                  lap_valid,
  output logic [DATA_WIDTH-1:0] lap_data,
  output logic                  lap_full,
  output logic                  lap_overflow,
  output logic [1:0]            state_dbg
);

  localparam int PTR_W = $clog2(LAP_DEPTH);
  localparam int OCC_W = PTR_W + 1;
  localparam logic [DATA_WIDTH-1:0] MAX_V   = DATA_WIDTH'(MAX);
  localparam logic [OCC_W-1:0]      DEPTH_V = OCC_W'(LAP_DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] count_q, count_d;
  logic                  wrap_q, wrap_d;

  logic [DATA_WIDTH-1:0] mem_q [LAP_DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [LAP_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0]      occ_q, occ_d;
  logic                  valid_q, valid_d;
  logic                  full_q, full_d;
  logic                  ovf_q, ovf_d;

  logic                  push_req;
  logic                  do_push;
  logic                  do_pop;

  // FSM next state: clear beats stop, stop beats start.
  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = IDLE;
    end else if (stop) begin
      if (state_q == RUN) state_d = HOLD;
    end else if (start) begin
      if (state_q == IDLE || state_q == HOLD) state_d = RUN;
    end
  end

  // Count update: steps only when already running and not being stopped;
  // anything above MAX (only reachable via preset) wraps on the next step.
  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    if (clear) begin
      count_d = '0;
    end else if (state_q == RUN && !stop) begin
      if (!dir) begin
        if (count_q >= MAX_V) begin
          count_d = '0;
          wrap_d  = 1'b1;
        end else begin
          count_d = count_q + DATA_WIDTH'(1);
        end
      end else begin
        if (count_q == '0 || count_q > MAX_V) begin
          count_d = MAX_V;
          wrap_d  = 1'b1;
        end else begin
          count_d = count_q - DATA_WIDTH'(1);
        end
      end
    end
`ifdef STOPWATCH_PRESET_EN
    else if (preset_load && state_q != RUN) begin
      count_d = preset_value;
    end
`endif
  end

  // Lap FIFO: push captures the pre-update count; a push into a full FIFO
  // succeeds only when a pop frees a slot on the same edge.
  always_comb begin
    push_req = lap && !clear;
    do_pop   = valid_q && lap_ready && !clear;
    do_push  = push_req && (occ_q != DEPTH_V || do_pop);

    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    ovf_d    = ovf_q;

    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      occ_d    = '0;
      ovf_d    = 1'b0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = count_q;
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   occ_d = occ_q + OCC_W'(1);
        2'b01:   occ_d = occ_q - OCC_W'(1);
        default: occ_d = occ_q;
      endcase
      if (push_req && !do_push) begin
        ovf_d = 1'b1;
      end
    end

    valid_d = (occ_d != '0);
    full_d  = (occ_d == DEPTH_V);
  end

  // State, count and wrap registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      count_q <= '0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      wrap_q  <= wrap_d;
    end
  end

  // FIFO storage, pointers, occupancy and registered flags.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < LAP_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      valid_q  <= 1'b0;
      full_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
      valid_q  <= valid_d;
      full_q   <= full_d;
      ovf_q    <= ovf_d;
    end
  end

  assign count        = count_q;
  assign running      = (state_q == RUN);
  assign wrap         = wrap_q;
  assign lap_valid    = valid_q;
  assign lap_data     = mem_q[rd_ptr_q];
  assign lap_full     = full_q;
  assign lap_overflow = ovf_q;
  assign state_dbg    = state_q;

endmodule

// File: tb/tb_stopwatch_lap_timer.sv
// Bench for stopwatch_lap_timer. Instance a uses MAX=5 for counting and
// FSM vectors; instance b uses MAX=99 for lap FIFO and reset sequences.
// Both share the same stimulus.
module tb_stopwatch_lap_timer;

  localparam int DW = 16;

  logic clk;
  logic resetn;
  logic start, stop, clear, dir, lap, lap_ready;
`ifdef STOPWATCH_PRESET_EN
  logic          preset_load;
  logic [DW-1:0] preset_value;
`endif

  logic [DW-1:0] count_a, lap_data_a, count_b, lap_data_b;
  logic running_a, wrap_a, lap_valid_a, lap_full_a, lap_overflow_a;
  logic running_b, wrap_b, lap_valid_b, lap_full_b, lap_overflow_b;
  logic [1:0] state_a, state_b;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic          start;
    logic          stop;
    logic          clear;
    logic          dir;
    logic [DW-1:0] exp_count;
    logic          exp_running;
    logic          exp_wrap;
  } vec_t;

  vec_t vecs [27];

  stopwatch_lap_timer #(.DATA_WIDTH(DW), .MAX(5), .LAP_DEPTH(4)) dut_a (
    .clk(clk), .resetn(resetn), .start(start), .stop(stop), .clear(clear),
    .dir(dir), .lap(lap), .lap_ready(lap_ready),
`ifdef STOPWATCH_PRESET_EN
    .preset_load(preset_load), .preset_value(preset_value),
`endif
    .count(count_a), .running(running_a), .wrap(wrap_a),
    .lap_valid(lap_valid_a), .lap_data(lap_data_a), .lap_full(lap_full_a),
    .lap_overflow(lap_overflow_a), .state_dbg(state_a)
  );

  stopwatch_lap_timer #(.DATA_WIDTH(DW), .MAX(99), .LAP_DEPTH(4)) dut_b (
    .clk(clk), .resetn(resetn), .start(start), .stop(stop), .clear(clear),
    .dir(dir), .lap(lap), .lap_ready(lap_ready),
`ifdef STOPWATCH_PRESET_EN
    .preset_load(preset_load), .preset_value(preset_value),
`endif
    .count(count_b), .running(running_b), .wrap(wrap_b),
    .lap_valid(lap_valid_b), .lap_data(lap_data_b), .lap_full(lap_full_b),
    .lap_overflow(lap_overflow_b), .state_dbg(state_b)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // One clock: inputs settle before the rising edge, outputs read at the falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic run_to(input logic [DW-1:0] target);
    int n = 0;
    while (count_b !== target && n < 300) begin
      step();
      n++;
    end
    if (n >= 300) check("run_to_timeout", 32'(count_b), 32'(target));
  endtask

  task automatic lap_at(input logic [DW-1:0] target);
    run_to(target);
    lap = 1'b1;
    step();
    lap = 1'b0;
  endtask

  task automatic drain_expect(input logic [DW-1:0] value);
    check("drain_valid", 32'(lap_valid_b), 32'd1);
    check("drain_data", 32'(lap_data_b), 32'(value));
    lap_ready = 1'b1;
    step();
    lap_ready = 1'b0;
  endtask

  task automatic start_b();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  initial begin
    // start stop clear dir | count running wrap   (instance a, MAX=5)
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 16'd0, 1'b1, 1'b0};
    vecs[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, 16'd1, 1'b1, 1'b0};
    vecs[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 16'd2, 1'b1, 1'b0};
    vecs[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 16'd3, 1'b1, 1'b0};
    vecs[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, 16'd4, 1'b1, 1'b0};
    vecs[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 16'd5, 1'b1, 1'b0};
    vecs[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 1'b1, 1'b1};
    vecs[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 16'd1, 1'b1, 1'b0};
    vecs[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 16'd2, 1'b1, 1'b0};
    vecs[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 16'd3, 1'b1, 1'b0};
    vecs[10] = '{1'b1, 1'b1, 1'b0, 1'b0, 16'd3, 1'b0, 1'b0};
    vecs[11] = '{1'b0, 1'b0, 1'b1, 1'b0, 16'd0, 1'b0, 1'b0};
    vecs[12] = '{1'b1, 1'b1, 1'b0, 1'b0, 16'd0, 1'b0, 1'b0};
    vecs[13] = '{1'b0, 1'b1, 1'b0, 1'b0, 16'd0, 1'b0, 1'b0};
    vecs[14] = '{1'b1, 1'b0, 1'b0, 1'b1, 16'd0, 1'b1, 1'b0};
    vecs[15] = '{1'b0, 1'b0, 1'b0, 1'b1, 16'd5, 1'b1, 1'b1};
    vecs[16] = '{1'b0, 1'b0, 1'b0, 1'b1, 16'd4, 1'b1, 1'b0};
    vecs[17] = '{1'b0, 1'b0, 1'b0, 1'b1, 16'd3, 1'b1, 1'b0};
    vecs[18] = '{1'b0, 1'b1, 1'b0, 1'b1, 16'd3, 1'b0, 1'b0};
    vecs[19] = '{1'b0, 1'b0, 1'b0, 1'b1, 16'd3, 1'b0, 1'b0};
    vecs[20] = '{1'b1, 1'b0, 1'b0, 1'b1, 16'd3, 1'b1, 1'b0};
    vecs[21] = '{1'b0, 1'b0, 1'b0, 1'b1, 16'd2, 1'b1, 1'b0};
    vecs[22] = '{1'b1, 1'b0, 1'b0, 1'b1, 16'd1, 1'b1, 1'b0};
    vecs[23] = '{1'b0, 1'b0, 1'b0, 1'b1, 16'd0, 1'b1, 1'b0};
    vecs[24] = '{1'b0, 1'b0, 1'b0, 1'b1, 16'd5, 1'b1, 1'b1};
    vecs[25] = '{1'b0, 1'b1, 1'b0, 1'b1, 16'd5, 1'b0, 1'b0};
    vecs[26] = '{1'b0, 1'b0, 1'b1, 1'b0, 16'd0, 1'b0, 1'b0};

    resetn = 1'b0;
    start = 1'b0; stop = 1'b0; clear = 1'b0; dir = 1'b0;
    lap = 1'b0; lap_ready = 1'b0;
`ifdef STOPWATCH_PRESET_EN
    preset_load = 1'b0;
    preset_value = '0;
`endif

    // Reset values
    repeat (2) @(negedge clk);
    check("rst_count", 32'(count_a), 32'd0);
    check("rst_running", 32'(running_a), 32'd0);
    check("rst_wrap", 32'(wrap_a), 32'd0);
    check("rst_lap_valid", 32'(lap_valid_a), 32'd0);
    check("rst_lap_full", 32'(lap_full_a), 32'd0);
    check("rst_lap_overflow", 32'(lap_overflow_a), 32'd0);
    resetn = 1'b1;
    step();
    check("idle_after_release", 32'(count_a), 32'd0);

    // Counting / FSM vectors
    for (int i = 0; i < 27; i++) begin
      start = vecs[i].start;
      stop  = vecs[i].stop;
      clear = vecs[i].clear;
      dir   = vecs[i].dir;
      step();
      check($sformatf("vec%0d_count", i), 32'(count_a), 32'(vecs[i].exp_count));
      check($sformatf("vec%0d_running", i), 32'(running_a), 32'(vecs[i].exp_running));
      check($sformatf("vec%0d_wrap", i), 32'(wrap_a), 32'(vecs[i].exp_wrap));
    end
    start = 1'b0; stop = 1'b0; clear = 1'b0; dir = 1'b0;

    // Lap FIFO fill, overflow, drain (instance b)
    start_b();
    check("b_running", 32'(running_b), 32'd1);
    lap_at(16'd2);
    check("one_entry_valid", 32'(lap_valid_b), 32'd1);
    check("one_entry_data", 32'(lap_data_b), 32'd2);
    lap_at(16'd4);
    lap_at(16'd6);
    lap_at(16'd8);
    check("full_after_4", 32'(lap_full_b), 32'd1);
    check("no_ovf_after_4", 32'(lap_overflow_b), 32'd0);
    lap_at(16'd10);
    check("full_after_5", 32'(lap_full_b), 32'd1);
    check("ovf_after_5", 32'(lap_overflow_b), 32'd1);
    drain_expect(16'd2);
    check("not_full_after_pop", 32'(lap_full_b), 32'd0);
    drain_expect(16'd4);
    drain_expect(16'd6);
    drain_expect(16'd8);
    check("empty_after_drain", 32'(lap_valid_b), 32'd0);
    lap_ready = 1'b1;
    step();
    lap_ready = 1'b0;
    check("pop_empty_ignored", 32'(lap_valid_b), 32'd0);
    check("ovf_sticky", 32'(lap_overflow_b), 32'd1);
    clear = 1'b1;
    lap = 1'b1;
    step();
    clear = 1'b0;
    lap = 1'b0;
    check("clear_ovf", 32'(lap_overflow_b), 32'd0);
    check("clear_beats_lap", 32'(lap_valid_b), 32'd0);
    check("clear_count", 32'(count_b), 32'd0);

    // Full FIFO with simultaneous push and pop
    start_b();
    lap_at(16'd2);
    lap_at(16'd4);
    lap_at(16'd6);
    lap_at(16'd8);
    run_to(16'd12);
    check("pp_head_before", 32'(lap_data_b), 32'd2);
    check("pp_full_before", 32'(lap_full_b), 32'd1);
    lap = 1'b1;
    lap_ready = 1'b1;
    step();
    lap = 1'b0;
    lap_ready = 1'b0;
    check("pp_full_after", 32'(lap_full_b), 32'd1);
    check("pp_no_ovf", 32'(lap_overflow_b), 32'd0);
    drain_expect(16'd4);
    drain_expect(16'd6);
    drain_expect(16'd8);
    drain_expect(16'd12);
    check("pp_empty", 32'(lap_valid_b), 32'd0);

    // Asynchronous reset mid-run with laps queued
    clear = 1'b1;
    step();
    clear = 1'b0;
    start_b();
    lap_at(16'd2);
    lap_at(16'd4);
    run_to(16'd7);
    check("pre_rst_valid", 32'(lap_valid_b), 32'd1);
    check("pre_rst_running", 32'(running_b), 32'd1);
    #2 resetn = 1'b0;
    #1;
    check("async_rst_count", 32'(count_b), 32'd0);
    check("async_rst_valid", 32'(lap_valid_b), 32'd0);
    check("async_rst_running", 32'(running_b), 32'd0);
    check("async_rst_full", 32'(lap_full_b), 32'd0);
    check("async_rst_ovf", 32'(lap_overflow_b), 32'd0);
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("post_rst_count%0d", i), 32'(count_b), 32'd0);
      check($sformatf("post_rst_running%0d", i), 32'(running_b), 32'd0);
    end
    start_b();
    check("restart_running", 32'(running_b), 32'd1);
    check("restart_count0", 32'(count_b), 32'd0);
    step();
    check("restart_count1", 32'(count_b), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
